// File: rtl/vdma_seq_pkg.sv
// vdma_seq_pkg: shared FSM state codes, error codes and AXI constants for the VDMA read sequencer
package vdma_seq_pkg;

    typedef logic [3:0] seq_state_t;

    localparam seq_state_t S_IDLE    = 4'd0;
    localparam seq_state_t S_INIT_AW = 4'd1;
    localparam seq_state_t S_INIT_B  = 4'd2;
    localparam seq_state_t S_ARMED   = 4'd3;
    localparam seq_state_t S_TRIG_AW = 4'd4;
    localparam seq_state_t S_TRIG_B  = 4'd5;
    localparam seq_state_t S_STAT_AR = 4'd6;
    localparam seq_state_t S_STAT_R  = 4'd7;
    localparam seq_state_t S_ERROR   = 4'd8;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RESP    = 2'd1,
        ERR_DMASR   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0] DMASR_ERR_MASK = 32'h70;

    function automatic logic is_busy(input seq_state_t s);
        return !(s == S_IDLE || s == S_ARMED || s == S_ERROR);
    endfunction

endpackage

// File: rtl/vdma_read_sequencer_wr_chan.sv
// axil_wr_chan: paired AW/W valid generation where each channel completes independently
module axil_wr_chan
    import vdma_seq_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic abort_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic done_o
);

    logic aw_q, aw_d, w_q, w_d, act_q, act_d;

    // done fires on the edge where the last outstanding handshake completes
    assign done_o    = act_q & (~aw_q | awready_i) & (~w_q | wready_i);
    assign awvalid_o = aw_q;
    assign wvalid_o  = w_q;

    // Valids rise together on start and each falls only on its own handshake or an abort
    always_comb begin
        aw_d  = start_i | (aw_q & ~awready_i & ~abort_i);
        w_d   = start_i | (w_q & ~wready_i & ~abort_i);
        act_d = start_i | (act_q & ~done_o & ~abort_i);
    end

    // Channel state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_q  <= 1'b0;
            w_q   <= 1'b0;
            act_q <= 1'b0;
        end else begin
            aw_q  <= aw_d;
            w_q   <= w_d;
            act_q <= act_d;
        end
    end

endmodule

// File: rtl/vdma_read_sequencer.sv
// vdma_read_sequencer: AXI4-Lite master that programs the VDMA MM2S init table and sequences frames.
// Define VDMA_SEQ_STATUS_READBACK_EN to read DMASR back after every frame write.
module vdma_read_sequencer
    import vdma_seq_pkg::*;
#(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          NUM_CFG            = 4,
    parameter logic [31:0] VSIZE_ADDR         = 32'h50,
    parameter logic [31:0] STATUS_ADDR        = 32'h04,
    parameter int          TIMEOUT            = 1024
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          start_i,
    input  logic [NUM_CFG*32-1:0]         cfg_addr_i,
    input  logic [NUM_CFG*32-1:0]         cfg_data_i,
    input  logic                          trigger_i,
    input  logic [12:0]                   vsize_i,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic                          init_done_o,
    output logic                          busy_o,
    output logic                          err_o,
    output logic [1:0]                    err_code_o,
    output logic [15:0]                   frame_cnt_o
);

    seq_state_t                    state_q, state_d;
    logic [3:0]                    idx_q, idx_d, nidx;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]                   wdata_q, wdata_d, tmo_q, tmo_d;
    logic                          pend_q, pend_d, init_done_q, init_done_d;
    err_code_t                     code_q, code_d;
    logic [15:0]                   frame_q, frame_d;
    logic                          wr_start, wr_done, busy, tmo_hit, abort;

    assign busy    = is_busy(state_q);
    assign tmo_hit = tmo_q == 32'(TIMEOUT - 1);
    assign nidx    = idx_q + 4'd1;
    assign abort   = state_d == S_ERROR;

    axil_wr_chan u_wr (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .start_i   (wr_start),
        .abort_i   (abort),
        .awready_i (m_axi_awready),
        .wready_i  (m_axi_wready),
        .awvalid_o (m_axi_awvalid),
        .wvalid_o  (m_axi_wvalid),
        .done_o    (wr_done)
    );

    assign m_axi_awaddr = awaddr_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = 4'hF;
    assign m_axi_arprot = 3'b000;
    assign m_axi_bready = state_q == S_INIT_B || state_q == S_TRIG_B;
`ifdef VDMA_SEQ_STATUS_READBACK_EN
    assign m_axi_arvalid = state_q == S_STAT_AR;
    assign m_axi_araddr  = m_axi_arvalid ? C_M_AXI_ADDR_WIDTH'(STATUS_ADDR) : '0;
    assign m_axi_rready  = state_q == S_STAT_R;
`else
    logic unused_rd;
    assign unused_rd     = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, STATUS_ADDR};
    assign m_axi_arvalid = 1'b0;
    assign m_axi_araddr  = '0;
    assign m_axi_rready  = 1'b0;
`endif
    assign init_done_o = init_done_q;
    assign busy_o      = busy;
    assign err_o       = state_q == S_ERROR;
    assign err_code_o  = code_q;
    assign frame_cnt_o = frame_q;

    // Sequencer next-state; any wait state that outlives TIMEOUT cycles falls into ERROR
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        pend_d      = pend_q | (trigger_i & busy);
        init_done_d = init_done_q;
        frame_d     = frame_q;
        code_d      = code_q;
        wr_start    = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d  = S_INIT_AW;
                idx_d    = '0;
                awaddr_d = C_M_AXI_ADDR_WIDTH'(cfg_addr_i[31:0]);
                wdata_d  = cfg_data_i[31:0];
                wr_start = 1'b1;
            end
            S_INIT_AW, S_TRIG_AW: if (wr_done) begin
                state_d = (state_q == S_INIT_AW) ? S_INIT_B : S_TRIG_B;
            end else if (tmo_hit) begin
                state_d = S_ERROR;
                code_d  = ERR_TIMEOUT;
            end
            S_INIT_B, S_TRIG_B: if (m_axi_bvalid) begin
                if (m_axi_bresp != AXI_RESP_OKAY) begin
                    state_d = S_ERROR;
                    code_d  = ERR_RESP;
                end else if (state_q == S_TRIG_B) begin
`ifdef VDMA_SEQ_STATUS_READBACK_EN
                    state_d = S_STAT_AR;
`else
                    state_d = S_ARMED;
                    frame_d = frame_q + 16'd1;
`endif
                end else if (idx_q != 4'(NUM_CFG - 1)) begin
                    state_d  = S_INIT_AW;
                    idx_d    = nidx;
                    awaddr_d = C_M_AXI_ADDR_WIDTH'(cfg_addr_i[32*nidx +: 32]);
                    wdata_d  = cfg_data_i[32*nidx +: 32];
                    wr_start = 1'b1;
                end else begin
                    state_d     = S_ARMED;
                    init_done_d = 1'b1;
                end
            end else if (tmo_hit) begin
                state_d = S_ERROR;
                code_d  = ERR_TIMEOUT;
            end
            S_ARMED: if (trigger_i || pend_q) begin
                state_d  = S_TRIG_AW;
                pend_d   = 1'b0;
                awaddr_d = C_M_AXI_ADDR_WIDTH'(VSIZE_ADDR);
                wdata_d  = {19'b0, vsize_i};
                wr_start = 1'b1;
            end
`ifdef VDMA_SEQ_STATUS_READBACK_EN
            S_STAT_AR: if (m_axi_arready) begin
                state_d = S_STAT_R;
            end else if (tmo_hit) begin
                state_d = S_ERROR;
                code_d  = ERR_TIMEOUT;
            end
            S_STAT_R: if (m_axi_rvalid) begin
                if (m_axi_rresp != AXI_RESP_OKAY) begin
                    state_d = S_ERROR;
                    code_d  = ERR_RESP;
                end else if ((m_axi_rdata & DMASR_ERR_MASK) != '0) begin
                    state_d = S_ERROR;
                    code_d  = ERR_DMASR;
                end else begin
                    state_d = S_ARMED;
                    frame_d = frame_q + 16'd1;
                end
            end else if (tmo_hit) begin
                state_d = S_ERROR;
                code_d  = ERR_TIMEOUT;
            end
`endif
            default: ;
        endcase
        tmo_d = (state_d != state_q) ? '0 : tmo_q + 32'd1;
    end

    // Sequencer state registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            tmo_q       <= '0;
            pend_q      <= 1'b0;
            init_done_q <= 1'b0;
            code_q      <= ERR_NONE;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
            init_done_q <= init_done_d;
            code_q      <= code_d;
            frame_q     <= frame_d;
        end
    end

endmodule

// File: tb/tb_vdma_read_sequencer.sv
// tb_vdma_read_sequencer: directed self-checking bench with a small AXI4-Lite slave model
module tb_vdma_read_sequencer;

    logic         ACLK = 1'b0;
    logic         ARESET, start_i, trigger_i;
    logic [127:0] cfg_addr_i, cfg_data_i;
    logic [12:0]  vsize_i;
    logic [31:0]  m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]   m_axi_awprot, m_axi_arprot;
    logic [3:0]   m_axi_wstrb;
    logic         m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]   m_axi_bresp, m_axi_rresp;
    logic         m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic         m_axi_rvalid, m_axi_rready;
    logic         init_done_o, busy_o, err_o;
    logic [1:0]   err_code_o;
    logic [15:0]  frame_cnt_o;

    int checks = 0;
    int errors = 0;

    logic        aw_rdy = 1'b1, w_rdy = 1'b1, ar_rdy = 1'b1, b_en = 1'b1, r_en = 1'b1;
    int          err_at = -1;
    int          n_b = 0;
    logic [31:0] rdata_k = '0;
    logic [31:0] aw_log[$], w_log[$], ar_log[$];
    logic        aw_got, w_got, ar_got;
    logic        aw_hs, w_hs, ar_hs;

    always #5 ACLK = ~ACLK;

    vdma_read_sequencer dut (
        .ACLK(ACLK), .ARESET(ARESET), .start_i(start_i),
        .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
        .trigger_i(trigger_i), .vsize_i(vsize_i),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .init_done_o(init_done_o), .busy_o(busy_o), .err_o(err_o),
        .err_code_o(err_code_o), .frame_cnt_o(frame_cnt_o)
    );

    assign m_axi_awready = aw_rdy;
    assign m_axi_wready  = w_rdy;
    assign m_axi_arready = ar_rdy;
    assign m_axi_rresp   = 2'b00;
    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;

    // Slave model: logs accepted addresses/data, answers B once AW and W are both in, R after AR
    always @(posedge ACLK) begin
        if (!ARESET && aw_hs) aw_log.push_back(m_axi_awaddr);
        if (!ARESET && w_hs) w_log.push_back(m_axi_wdata);
        if (!ARESET && ar_hs) ar_log.push_back(m_axi_araddr);
        if (ARESET) begin
            m_axi_bvalid <= 1'b0;
            m_axi_bresp  <= 2'b00;
            m_axi_rvalid <= 1'b0;
            m_axi_rdata  <= '0;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            ar_got       <= 1'b0;
        end else begin
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0;
            end else if ((aw_got | aw_hs) && (w_got | w_hs) && b_en && !m_axi_bvalid) begin
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= (n_b == err_at) ? 2'b10 : 2'b00;
                n_b          <= n_b + 1;
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
            end else begin
                aw_got <= aw_got | aw_hs;
                w_got  <= w_got | w_hs;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                m_axi_rvalid <= 1'b0;
            end else if ((ar_got | ar_hs) && r_en && !m_axi_rvalid) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= rdata_k;
                ar_got       <= 1'b0;
            end else begin
                ar_got <= ar_got | ar_hs;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge ACLK) start_i = 1'b1;
        @(negedge ACLK) start_i = 1'b0;
    endtask

    task automatic pulse_trigger();
        @(negedge ACLK) trigger_i = 1'b1;
        @(negedge ACLK) trigger_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_init_done"}, 32'(init_done_o), 32'd0);
        check({pfx, "_busy"}, 32'(busy_o), 32'd0);
        check({pfx, "_err"}, 32'(err_o), 32'd0);
        check({pfx, "_err_code"}, 32'(err_code_o), 32'd0);
        check({pfx, "_frame_cnt"}, 32'(frame_cnt_o), 32'd0);
        check({pfx, "_valids"}, 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'd0);
        check({pfx, "_readies"}, 32'({m_axi_bready, m_axi_rready}), 32'd0);
        check({pfx, "_awaddr"}, m_axi_awaddr, 32'd0);
        check({pfx, "_wdata"}, m_axi_wdata, 32'd0);
        check({pfx, "_wstrb"}, 32'(m_axi_wstrb), 32'hF);
    endtask

    initial begin
        logic [31:0] exp_a[4] = '{32'h00, 32'h5C, 32'h54, 32'h58};
        logic [31:0] exp_d[4] = '{32'h3, 32'h1000_0000, 32'h1E00, 32'h1E00};
        int nb0, naw0;
        ARESET = 1'b1;
        start_i = 1'b0;
        trigger_i = 1'b0;
        vsize_i = '0;
        cfg_addr_i = {exp_a[3], exp_a[2], exp_a[1], exp_a[0]};
        cfg_data_i = {exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
        repeat (2) @(negedge ACLK);
        check_idle_outputs("reset");
        ARESET = 1'b0;

        // Init table, slave always ready
        pulse_start();
        check("init_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 100 && !init_done_o; i++) @(negedge ACLK);
        check("init_done", 32'(init_done_o), 32'd1);
        check("init_idle_busy", 32'(busy_o), 32'd0);
        check("init_aw_count", 32'(aw_log.size()), 32'd4);
        check("init_w_count", 32'(w_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("init_awaddr%0d", i), aw_log[i], exp_a[i]);
            check($sformatf("init_wdata%0d", i), w_log[i], exp_d[i]);
        end

        // First frame: vsize 1080
        vsize_i = 13'd1080;
        pulse_trigger();
        for (int i = 0; i < 100 && frame_cnt_o != 16'd1; i++) @(negedge ACLK);
        check("trig_frame_cnt", 32'(frame_cnt_o), 32'd1);
        check("trig_awaddr", aw_log[4], 32'h50);
        check("trig_wdata", w_log[4], 32'h438);
        check("trig_busy", 32'(busy_o), 32'd0);
`ifdef VDMA_SEQ_STATUS_READBACK_EN
        check("trig_ar_count", 32'(ar_log.size()), 32'd1);
        check("trig_araddr", ar_log[0], 32'h04);
`else
        check("trig_no_ar", 32'(ar_log.size()), 32'd0);
`endif

        // Backpressure: W stalls 2 cycles, AW stalls 5 cycles
        aw_rdy = 1'b0;
        w_rdy = 1'b0;
        vsize_i = 13'd720;
        nb0 = n_b;
        pulse_trigger();
        check("bp_valids_c1", 32'({m_axi_awvalid, m_axi_wvalid}), 32'b11);
        @(negedge ACLK);
        check("bp_valids_c2", 32'({m_axi_awvalid, m_axi_wvalid}), 32'b11);
        w_rdy = 1'b1;
        @(negedge ACLK);
        check("bp_w_dropped", 32'({m_axi_awvalid, m_axi_wvalid}), 32'b10);
        check("bp_no_bready", 32'(m_axi_bready), 32'd0);
        repeat (2) @(negedge ACLK);
        check("bp_aw_held", 32'({m_axi_awvalid, m_axi_awaddr[7:0]}), 32'h150);
        aw_rdy = 1'b1;
        @(negedge ACLK);
        check("bp_aw_dropped", 32'(m_axi_awvalid), 32'd0);
        for (int i = 0; i < 100 && frame_cnt_o != 16'd2; i++) @(negedge ACLK);
        check("bp_frame_cnt", 32'(frame_cnt_o), 32'd2);
        check("bp_single_b", 32'(n_b - nb0), 32'd1);
        check("bp_wdata", w_log[5], 32'h2D0);

        // Pending triggers collapse to a single extra frame
        b_en = 1'b0;
        r_en = 1'b0;
        naw0 = aw_log.size();
        pulse_trigger();
        for (int i = 0; i < 50 && !m_axi_bready; i++) @(negedge ACLK);
        check("pend_in_trig_b", 32'(m_axi_bready), 32'd1);
        pulse_trigger();
        pulse_trigger();
        b_en = 1'b1;
`ifdef VDMA_SEQ_STATUS_READBACK_EN
        for (int i = 0; i < 50 && !m_axi_rready; i++) @(negedge ACLK);
        check("pend_in_stat_r", 32'(m_axi_rready), 32'd1);
        pulse_trigger();
`endif
        r_en = 1'b1;
        for (int i = 0; i < 200 && frame_cnt_o != 16'd4; i++) @(negedge ACLK);
        repeat (30) @(negedge ACLK);
        check("pend_frame_cnt", 32'(frame_cnt_o), 32'd4);
        check("pend_aw_count", 32'(aw_log.size() - naw0), 32'd2);
        check("pend_busy", 32'(busy_o), 32'd0);

`ifdef VDMA_SEQ_STATUS_READBACK_EN
        // DMASR reports an internal error
        rdata_k = 32'h40;
        pulse_trigger();
        for (int i = 0; i < 100 && !err_o; i++) @(negedge ACLK);
        check("dmasr_err", 32'(err_o), 32'd1);
        check("dmasr_code", 32'(err_code_o), 32'd2);
        check("dmasr_frame_cnt", 32'(frame_cnt_o), 32'd4);
        check("dmasr_busy", 32'(busy_o), 32'd0);
        rdata_k = '0;
`endif

        @(negedge ACLK) ARESET = 1'b1;
        @(negedge ACLK) ARESET = 1'b0;
        check_idle_outputs("rst2");

        // SLVERR on the second init write
        err_at = n_b + 1;
        naw0 = aw_log.size();
        pulse_start();
        for (int i = 0; i < 100 && !err_o; i++) @(negedge ACLK);
        repeat (20) @(negedge ACLK);
        check("bresp_err", 32'(err_o), 32'd1);
        check("bresp_code", 32'(err_code_o), 32'd1);
        check("bresp_aw_count", 32'(aw_log.size() - naw0), 32'd2);
        check("bresp_no_init_done", 32'(init_done_o), 32'd0);
        check("bresp_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
        err_at = -1;

        @(negedge ACLK) ARESET = 1'b1;
        @(negedge ACLK) ARESET = 1'b0;

        // B never arrives: timeout after 1024 cycles in INIT_B
        b_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 20 && !m_axi_bready; i++) @(negedge ACLK);
        check("tmo_in_b", 32'(m_axi_bready), 32'd1);
        repeat (1000) @(negedge ACLK);
        check("tmo_not_early", 32'(err_o), 32'd0);
        for (int i = 0; i < 100 && !err_o; i++) @(negedge ACLK);
        check("tmo_err", 32'(err_o), 32'd1);
        check("tmo_code", 32'(err_code_o), 32'd3);
        check("tmo_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
        check("tmo_busy", 32'(busy_o), 32'd0);

        @(negedge ACLK) ARESET = 1'b1;
        @(negedge ACLK);
        check_idle_outputs("rst3");
        ARESET = 1'b0;
        b_en = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst3_stays_idle", 32'({busy_o, m_axi_awvalid}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdma_read_sequencer.md
Name: vdma_read_sequencer

Overview:
- AXI4-Lite master that configures and sequences the VDMA MM2S (read) channel.
- On `start_i` it writes an init table of register/value pairs into the VDMA.
- After init, each `trigger_i` pulse starts one read frame by writing MM2S_VSIZE, then reads back DMASR to check for errors.
- Sits between the frame-timing logic and the VDMA AXI4-Lite slave port; it is the block that sequences the read datapath.

Parameters:
- `C_M_AXI_ADDR_WIDTH`, 32: address width of the master port.
- `C_M_AXI_DATA_WIDTH`, 32: data width; only 32 is supported.
- `NUM_CFG`, 4: number of init table entries (1..16).
- `VSIZE_ADDR`, 32'h50: MM2S_VSIZE register offset.
- `STATUS_ADDR`, 32'h04: MM2S_DMASR register offset.
- `TIMEOUT`, 1024: cycles allowed for a response before a timeout error.

Ports:
- `ACLK` in 1: clock. Single clock domain.
- `ARESET` in 1: reset, synchronous, active-high.
- `start_i` in 1: pulse; begins the init sequence.
- `cfg_addr_i` in NUM_CFG*32: init table addresses; entry k is at bits [32k+31:32k].
- `cfg_data_i` in NUM_CFG*32: init table data, same packing.
- `trigger_i` in 1: frame-start pulse, one cycle wide.
- `vsize_i` in 13: line count written on each trigger.
- `m_axi_awaddr`/`awprot`/`awvalid` out, 32/3/1; `m_axi_awready` in 1.
- `m_axi_wdata`/`wstrb`/`wvalid` out, 32/4/1; `m_axi_wready` in 1.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1.
- `m_axi_araddr`/`arprot`/`arvalid` out, 32/3/1; `m_axi_arready` in 1.
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1.
- `init_done_o` out 1: init completed, sticky until reset.
- `busy_o` out 1: high whenever the FSM is not in IDLE, ARMED or ERROR.
- `err_o` out 1: sticky error flag.
- `err_code_o` out 2: 0 none, 1 bad BRESP/RRESP, 2 DMASR error, 3 timeout.
- `frame_cnt_o` out 16: completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. `awprot`/`arprot` are constant 0 and `wstrb` is constant 4'hF.
- Reset mid-transaction: all valids drop on the next edge and the pending flag clears. The VDMA is assumed reset by the same `ARESET`.
- FSM states: IDLE, INIT_AW, INIT_B, ARMED, TRIG_AW, TRIG_B, STAT_AR, STAT_R, ERROR.
- IDLE: `start_i` -> INIT_AW with index idx=0. Triggers are ignored in IDLE.
- INIT_AW / TRIG_AW: `awvalid` and `wvalid` assert together on entry. Each drops independently on the cycle its ready is sampled high. Valids never drop before their handshake. Addresses and data are held stable.
- Leaving AW states: once both handshakes have completed -> *_B. The earliest path is AW and W accepted on the same edge, followed by the B-state on the next cycle.
- *_B states: `bready`=1.
  - On `bvalid`, BRESP!=OKAY -> ERROR with code 1.
  - INIT_B with idx<NUM_CFG-1: idx++ and return to INIT_AW.
  - INIT_B at the last entry: set `init_done_o` and go to ARMED.
- ARMED: a trigger, or a pending trigger, -> TRIG_AW with awaddr=VSIZE_ADDR and wdata={19'b0,vsize_i}. `vsize_i` is sampled on entry to TRIG_AW.
- TRIG_B OKAY -> STAT_AR. STAT_AR asserts `arvalid` at STATUS_ADDR until `arready`, then -> STAT_R with `rready`=1.
- STAT_R on `rvalid`:
  - RRESP!=OKAY -> ERROR with code 1.
  - `rdata`[6:4] != 0 -> ERROR with code 2.
  - Otherwise `frame_cnt_o`++ and return to ARMED.
- Trigger while busy: one-deep pending flag, serviced on return to ARMED. Further triggers while the flag is already set are dropped.
- Trigger in ARMED on the same cycle the pending flag is set: treated as one trigger.
- Timeout counter: clears on entry to each AW/AR/B/R state. Reaching TIMEOUT -> ERROR with code 3, and all valids deassert.
- ERROR: terminal until `ARESET`. `err_o`=1 and `err_code_o` holds the first error.
- `start_i` outside IDLE is ignored.

Optional Feature:
- Macro `VDMA_SEQ_STATUS_READBACK_EN`.
- Defined: the STAT_AR/STAT_R read-back described above is performed.
- Undefined:
  - TRIG_B OKAY increments `frame_cnt_o` and returns directly to ARMED.
  - `arvalid` and `rready` are tied 0, and the STAT states are not built.
  - Error code 2 is unreachable.

Decomposition:
- Package `vdma_seq_pkg` holds:
  - the state enum `seq_state_t`;
  - `err_code_t` (ERR_NONE, ERR_RESP, ERR_DMASR, ERR_TIMEOUT);
  - the constants `AXI_RESP_OKAY`=2'b00 and `DMASR_ERR_MASK`=32'h70.
- One sub-module, `axil_wr_chan`: drives the independent AW/W valid-drop logic and reports `done`. It is instantiated once, shared by INIT and TRIG.

Test Plan:
- Init: NUM_CFG=4, table {0x00:0x3, 0x5C:0x1000_0000, 0x54:0x1E00, 0x58:0x1E00}, `start_i`, slave ready always high -> exactly 4 writes in that order, then `init_done_o`=1 and `busy_o`=0.
- Backpressure: hold `awready` low for 5 cycles and `wready` low for 2 -> `wvalid` drops after 2, `awvalid` drops after 5, then a single B.
- Trigger: `vsize_i`=1080 -> write of 0x438 to 0x50, DMASR read returns 0x0 -> `frame_cnt_o`=1.
- Pending triggers: two triggers during TRIG_B plus one during STAT_R -> exactly one further frame runs and `frame_cnt_o`=2.
- Errors:
  - BRESP=2'b10 on the second init write -> ERROR, `err_code_o`=1, and no further AW.
  - DMASR=0x40 -> `err_code_o`=2.
- Timeout: `bvalid` never asserts -> `err_o`=1 and `err_code_o`=3 after 1024 cycles. Then `ARESET` for one cycle -> all outputs 0 and state IDLE.
